// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   CPU data-port bus between a CPU (master) and the data-memory responder (slave).
//   d_mem_addr  : byte address from CPU
//   d_mem_wdata : store data, lane-aligned
//   d_mem_wen   : byte-lane write enables, 0000 = read/idle
//   d_mem_rdata : combinational read data back to the CPU
interface dmem_responder_if;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;

    modport master (output d_mem_addr, output d_mem_wdata, output d_mem_wen, input d_mem_rdata);
    modport slave  (input d_mem_addr, input d_mem_wdata, input d_mem_wen, output d_mem_rdata);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Slave end of the CPU data port: byte-lane-writable word RAM, a TOHOST
//   test-exit register and a console byte FIFO drained over valid/ready.
//   Optional macro DMEM_ALIGN_CHECK_EN: restricts legal wen patterns and adds
//   the sticky misalign_err output.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus           : dmem_responder_if.slave (addr / wdata / wen / rdata)
//   log_data      : console byte at FIFO head (registered)
//   log_valid     : FIFO non-empty
//   log_ready     : consumer accepts log_data when valid & ready
//   test_done     : sticky, TOHOST written with nonzero value
//   test_code     : TOHOST value[31:1] from the first nonzero write
//   oob_err       : sticky, access outside RAM and MMIO
//   log_ovf       : sticky, console byte dropped on a full FIFO
//   misalign_err  : sticky, illegal wen pattern (DMEM_ALIGN_CHECK_EN only)
module dmem_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] TOHOST_ADDR  = 32'hFFFF_FFF0,
    parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF_FFF4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    dmem_responder_if.slave     bus,
    output logic [7:0]          log_data,
    output logic                log_valid,
    input  logic                log_ready,
    output logic                test_done,
    output logic [30:0]         test_code,
    output logic                oob_err,
    output logic                log_ovf
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic                misalign_err
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [FW:0]   count, cnt_nxt;

    logic [AW-1:0] idx;
    logic          in_ram, is_tohost, is_console, is_oob;
    logic          wen_ok, push, push_ok, pop, full;

    assign idx        = bus.d_mem_addr[AW+1:2];
    assign in_ram     = bus.d_mem_addr < 32'(4 * DEPTH_WORDS);
    assign is_tohost  = (bus.d_mem_addr == TOHOST_ADDR);
    assign is_console = (bus.d_mem_addr == CONSOLE_ADDR);
    assign is_oob     = !in_ram && !is_tohost && !is_console;

    // Only contiguous, naturally aligned lane groups are legal when checking.
`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        case (bus.d_mem_wen)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: wen_ok = 1'b1;
            default:                   wen_ok = 1'b0;
        endcase
    end
`else
    assign wen_ok = 1'b1;
`endif

    assign log_valid = (count != '0);
    assign full      = (count == (FW+1)'(FIFO_DEPTH));
    assign pop       = log_valid && log_ready;
    assign push      = is_console && bus.d_mem_wen[0] && wen_ok;
    assign push_ok   = push && (!full || pop);
    assign rd_nxt    = rd_ptr + FW'(pop);
    assign cnt_nxt   = count + (FW+1)'(push_ok) - (FW+1)'(pop);

    // Combinational read; a same-cycle write lands on the edge, so the old word shows.
    always_comb begin
        bus.d_mem_rdata = 32'h0;
        if (in_ram)
            bus.d_mem_rdata = mem[idx];
        else if (is_tohost)
            bus.d_mem_rdata = {test_code, test_done};
        else if (is_console)
            bus.d_mem_rdata = {16'b0, 8'(count), 6'b0, log_ovf, log_valid};
    end

    // RAM contents survive reset; writes in the reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (!rst && in_ram && wen_ok) begin
            for (int i = 0; i < 4; i++)
                if (bus.d_mem_wen[i])
                    mem[idx][8*i +: 8] <= bus.d_mem_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            log_data  <= 8'h0;
            log_ovf   <= 1'b0;
            test_done <= 1'b0;
            test_code <= 31'h0;
            oob_err   <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= bus.d_mem_wdata[7:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            // Register the post-update head; when the new head is the byte being
            // pushed this cycle it is not in fifo_mem yet, so take it from wdata.
            if (cnt_nxt != '0)
                log_data <= (push_ok && rd_nxt == wr_ptr) ? bus.d_mem_wdata[7:0]
                                                          : fifo_mem[rd_nxt];
            if (push && full && !pop)
                log_ovf <= 1'b1;
            // First nonzero full-word exit write wins.
            if (is_tohost && bus.d_mem_wen == 4'b1111 && bus.d_mem_wdata != 32'h0 && !test_done) begin
                test_done <= 1'b1;
                test_code <= bus.d_mem_wdata[31:1];
            end
            if (is_oob)
                oob_err <= 1'b1;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            misalign_err <= 1'b0;
        else if (!wen_ok)
            misalign_err <= 1'b1;
    end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the CPU data port (d_mem_addr / d_mem_wdata / d_mem_wen / d_mem_rdata).
- Replaces the ad-hoc RAM model in benches and is synthesizable for FPGA bring-up.
- Provides a byte-lane-writable word RAM, a TOHOST test-exit register and a console byte FIFO.
- The FIFO is drained over a valid/ready stream so a bench or UART bridge can collect program output.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two).
- TOHOST_ADDR, 32'hFFFF_FFF0, byte address of the test-exit register.
- CONSOLE_ADDR, 32'hFFFF_FFF4, byte address of the console write port.
- FIFO_DEPTH, 8, console FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- d_mem_addr  in  32  byte address from CPU
- d_mem_wdata  in  32  store data, lane-aligned
- d_mem_wen  in  4  byte-lane write enables; 0000 = read/idle
- d_mem_rdata  out  32  read data, combinational
- log_data  out  8  console byte at FIFO head
- log_valid  out  1  FIFO non-empty
- log_ready  in  1  consumer accepts log_data when valid & ready
- test_done  out  1  sticky: TOHOST written with nonzero value
- test_code  out  31  TOHOST value[31:1] captured on first nonzero write
- oob_err  out  1  sticky: access outside RAM and outside MMIO
- log_ovf  out  1  sticky: console byte dropped because FIFO was full

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Reset, applied at any time, clears:
  - test_done=0, test_code=0, oob_err=0, log_ovf=0, log_valid=0;
  - FIFO pointers and count; log_data=0.
- Reset does not clear RAM contents. An in-flight write in the reset cycle is ignored.
- RAM region: d_mem_addr < 4*DEPTH_WORDS; index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
- RAM writes: on the rising edge with rst=0, each lane i with d_mem_wen[i]=1 writes wdata[8i+7:8i]. Other lanes are unchanged; any wen pattern is legal.
- RAM reads: d_mem_rdata = mem[index] combinationally, with zero added latency.
- Same-cycle read and write to one word: rdata shows the old value; the new value is visible from the next cycle.
- TOHOST:
  - Write with wen=1111 and wdata≠0, while test_done=0: set test_done and latch test_code = wdata[31:1].
  - Later writes are ignored (first exit wins).
  - Write of 0 is ignored.
  - Read returns {test_code, test_done}.
- CONSOLE write (wen[0]=1): push wdata[7:0].
  - FIFO full and no pop this cycle: byte dropped, log_ovf set.
  - Full with simultaneous pop: push accepted, count unchanged.
- CONSOLE read returns {16'b0, 8'(count), 6'b0, log_ovf, log_valid}.
- FIFO pop: occurs when log_valid & log_ready.
  - log_data always shows the head entry, registered (not a bypass). A byte pushed into an empty FIFO appears with log_valid=1 on the next cycle.
  - Order is strict FIFO; read/write pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - log_ready while empty has no effect.
- Out-of-bounds (address in neither RAM nor MMIO):
  - Writes are discarded; reads return 32'h0.
  - oob_err is set on any such write, and on a read only when wen=0000 and the address is outside RAM.
  - Because the CPU drives addresses every cycle, the bench must qualify OOB-read checks; oob_err is diagnostic only.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- When defined:
  - Legal wen patterns are 0000, 0001, 0010, 0100, 1000, 0011, 1100 and 1111.
  - Any other pattern (e.g. 0110, 0111, 1010) suppresses the write in all regions.
  - It also sets added output misalign_err (out, 1, sticky, reset 0).
- When undefined: no misalign_err port, and every pattern writes its lanes as above.

Test Plan:
- Word write 0x0000_0010 ← 0xDEADBEEF (wen 1111), then read -> rdata=0xDEADBEEF the next cycle; same-cycle read returns the old value 0x0.
- Byte-lane merge: write 0x11223344 (1111), then 0xAA00_0000 (wen 1000) to 0x20 -> read 0xAA223344.
- TOHOST: write 0x0000_0003 -> test_done=1 and test_code=1 the next cycle. A later write of 0x5 leaves code=1. Read of TOHOST = 0x3.
- Console: push 'H','i' with log_ready=0 -> log_valid=1, count=2, log_data='H'. Then hold ready=1 for 2 cycles -> 'H','i' delivered, log_valid=0.
- Overflow: 9 pushes with ready=0 (DEPTH 8) -> log_ovf=1 and 8 bytes retained in order. Then reset mid-drain -> all outputs 0 and the RAM word at 0x10 is still 0xDEADBEEF.
- OOB write to 0x0000_2000 -> oob_err=1 and RAM unchanged. With DMEM_ALIGN_CHECK_EN, wen 0110 -> misalign_err=1 and no lane written.
